// File: rtl/bcd_arb_pkg.sv
// rtl/bcd_arb_pkg.sv - shared types and constants for the BCD conversion arbiter
package bcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int BCD_BASE = 10;
    localparam int DIGIT_W  = 4;

endpackage

// File: rtl/div_mod.sv
// rtl/div_mod.sv - combinational divide/modulo by a constant base
module div_mod #(
    parameter int BASE  = 10,
    parameter int W_IN  = 9,
    parameter int W_MOD = 4,
    parameter int W_DIV = 9
) (
    input  logic [W_IN-1:0]  a,
    output logic [W_MOD-1:0] mod,
    output logic [W_DIV-1:0] div
);

    localparam logic [W_IN-1:0] B = W_IN'(BASE);

    assign mod = W_MOD'(a % B);
    assign div = W_DIV'(a / B);

endmodule

// File: rtl/bcd_convert_arbiter.sv
// rtl/bcd_convert_arbiter.sv - round-robin shared binary-to-BCD converter, one digit per clock
module bcd_convert_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int W_IN     = 9,
    parameter int N_DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*W_IN-1:0]         value,
    output logic [N_REQ-1:0]              grant,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(N_REQ)-1:0]      done_id,
    output logic [N_DIGITS*DIGIT_W-1:0]   digits,
    output logic                          ovf
);

    localparam int SEL_W = $clog2(N_REQ);
    localparam int IDX_W = $clog2(N_DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    state_t                        state;
    logic [SEL_W-1:0]              last;
    logic [SEL_W-1:0]              sel_next;
    logic [W_IN-1:0]               work;
    logic [W_IN-1:0]               operand;
    logic [IDX_W-1:0]              idx;
    logic [N_DIGITS*DIGIT_W-1:0]   shadow;
    logic [DIGIT_W-1:0]            mod;
    logic [W_IN-1:0]               div;

    // First set request strictly after the previous winner, wrapping around.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                  input logic [SEL_W-1:0] l);
        logic [SEL_W-1:0] pick;
        logic             found;
        int               c;
        pick  = l;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            c = (int'(l) + k) % N_REQ;
            if (!found && r[c]) begin
                pick  = SEL_W'(c);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        sel_next = rr_pick(req, last);
        operand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel_next == SEL_W'(k)) operand = value[k*W_IN +: W_IN];
        end
    end

    div_mod #(
        .BASE  (BCD_BASE),
        .W_IN  (W_IN),
        .W_MOD (DIGIT_W),
        .W_DIV (W_IN)
    ) u_div_mod (
        .a   (work),
        .mod (mod),
        .div (div)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= SEL_W'(N_REQ - 1);
            work    <= '0;
            idx     <= '0;
            shadow  <= '0;
            grant   <= '0;
            done    <= 1'b0;
            done_id <= '0;
            digits  <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_next;
                        work  <= operand;
                        idx   <= '0;
                        last  <= sel_next;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    for (int k = 0; k < N_DIGITS; k++) begin
                        if (idx == IDX_W'(k)) shadow[k*DIGIT_W +: DIGIT_W] <= mod;
                    end
                    work <= div;
                    idx  <= idx + 1'b1;
                    if (idx == LAST_IDX) state <= DONE;
                end
                DONE: begin
                    // Leftover quotient means the operand did not fit: saturate to all nines.
                    digits  <= (work != '0) ? {N_DIGITS{DIGIT_W'(9)}} : shadow;
                    ovf     <= (work != '0);
                    done_id <= last;
                    done    <= 1'b1;
                    grant   <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bcd_convert_arbiter.md
Name: bcd_convert_arbiter

Overview:
- Shares one combinational base-10 DIV_MOD stage among N_REQ requesters, such as the score, timer and attempt-counter displays.
- Converts a latched binary operand into N_DIGITS BCD digits iteratively, producing one digit per clock, least-significant digit first.
- Selects requesters by round-robin arbitration.
- Sits between the game-logic counters and the 7-segment display drivers.

Parameters:
- N_REQ, 2, number of requesters (>=2).
- W_IN, 9, operand width in bits.
- N_DIGITS, 3, number of BCD digits produced per conversion (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request, one bit per requester.
- value  in  N_REQ*W_IN  packed operands; requester i occupies bits [i*W_IN +: W_IN].
- grant  out  N_REQ  one-hot, high while requester i is being served.
- busy  out  1  high whenever the block is not in IDLE.
- done  out  1  one-cycle pulse when a result is valid.
- done_id  out  $clog2(N_REQ)  index of the requester whose result is on digits.
- digits  out  N_DIGITS*4  BCD result; digit k occupies bits [4k +: 4], k=0 is the units digit.
- ovf  out  1  operand was >= 10^N_DIGITS.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; grant=0, busy=0, done=0, done_id=0, digits=0, ovf=0.
  - Round-robin pointer last=N_REQ-1, so req[0] wins first after reset.
  - A conversion in progress is aborted; no done pulse is issued.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - If any req bit is set, choose the first set bit searching from last+1 upward, wrapping modulo N_REQ.
  - On that edge: grant=onehot(sel), latch value[sel] into the work register, idx=0, last=sel, state goes to CONVERT.
  - If no req bit is set, stay in IDLE.
- CONVERT, once per cycle:
  - DIV_MOD(work) supplies mod and div.
  - Write mod into shadow digit[idx]; work<=div; idx<=idx+1.
  - After the cycle with idx==N_DIGITS-1, go to DONE.
- DONE, on entry:
  - Copy the shadow digits to digits.
  - ovf<=(remaining work!=0). When ovf is set, every digit is forced to 4'd9 (saturate).
  - done_id<=sel, done=1 for exactly this cycle.
  - grant stays high through DONE and clears on the edge back to IDLE.
- Latency and throughput:
  - grant rises 1 cycle after req is seen.
  - done rises N_DIGITS+1 cycles after grant rises.
  - Busy period is N_DIGITS+1 cycles, followed by at least one IDLE cycle before the next grant.
- Output stability:
  - digits, ovf and done_id hold their values until the next DONE.
  - Intermediate digits are never visible on the outputs.
- Operand capture: value is sampled only at the grant edge; later changes do not affect the conversion in progress.
- req is a level signal:
  - If req drops mid-conversion, the conversion still completes and done still pulses.
  - If req is still held after done, that requester is re-arbitrated and competes normally.
- Simultaneous requests: served in round-robin order. With both of 2 requesters held continuously, grants alternate 0,1,0,1.
- DIV_MOD instance: base=10, W_in=W_IN, W_mod=4, W_div=W_IN.
- Datapath widths:
  - work is W_IN bits wide.
  - idx is $clog2(N_DIGITS+1) bits wide; the terminal comparison is done at full width to avoid wrap.

Decomposition:
- Package bcd_arb_pkg:
  - state enum {IDLE, CONVERT, DONE}.
  - BCD_BASE=10.
  - DIGIT_W=4.
- Sub-module: one instance of the existing DIV_MOD utility.
- Round-robin select is a local function inside the block; it is not a separate module.

Test Plan (N_REQ=2, W_IN=9, N_DIGITS=3 unless noted):
- Reset: hold rst_n=0 with req=2'b11 -> all outputs 0, busy=0, no grant.
- Single conversion: req=01, value0=357 -> grant=01 one cycle later; done pulses 4 cycles after grant rises; digits=12'h357, done_id=0, ovf=0.
- Arbitration: req=11 held, value0=12, value1=480 -> served 0,1,0; results 12'h012 (id 0), then 12'h480 (id 1), then 12'h012 (id 0); grant is always one-hot.
- Overflow (N_DIGITS=2 build): value0=511 -> ovf=1, digits=8'h99. Then value0=42 -> ovf=0, digits=8'h42.
- Request drop and zero operand: req0 pulsed for 1 cycle with value0=0 -> conversion completes, done pulses once, digits=12'h000; block returns to IDLE with busy=0.
- Mid-conversion reset: assert rst_n=0 during CONVERT -> outputs clear at once, no done pulse. After release with req=11 held, req[0] is granted first.
